lsu_ctrl: RTL and testbench

Load/store sequencer between the MEM stage and the data memory port. It turns MEM-stage load/store controls into a request/grant/response transaction on a word-addressed memory bus. It stalls the pipeline until the access completes, then delivers the aligned, sign/zero-extended load result on `dataR_o` for capture by the MEM/WB register. It also flags misaligned accesses, illegal sizes and response timeouts.

---
 rtl/lsu_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store sequencer sitting between the MEM stage and the data memory port.
// A MEM-stage load or store is turned into a request/grant/response transaction
// on a word-addressed bus. The pipeline is stalled until the access completes,
// then the aligned and sign/zero-extended load result is presented on dataR_o
// for capture by the MEM/WB register.
//
// Parameters
//   Width          data/address width (only 32 is supported; 4 byte lanes)
//   TimeoutCycles  WAIT cycles allowed before a bus error is declared (1..255)
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   ld_MEM, st_MEM       MEM-stage load / store (mutually exclusive)
//   funct3_MEM           access size and sign code
//   alu_MEM              byte address
//   wdata_MEM            store data (low bits used)
//   mem_req_o .. be_o    registered bus request fields, non-zero only in REQ
//   mem_gnt_i            request accepted this cycle
//   mem_rvalid_i/rdata_i read response
//   stall_o              hold PC, IF/ID, ID/EX and EX/MEM
//   dataR_o              extended load result, held until the next load
//   misalign_o           one-cycle pulse: misaligned access or illegal funct3
//   bus_err_o            one-cycle pulse in DONE after a response timeout
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned Width         = 32,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             ld_MEM,
    input  logic             st_MEM,
    input  logic [2:0]       funct3_MEM,
    input  logic [Width-1:0] alu_MEM,
    input  logic [Width-1:0] wdata_MEM,

    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [Width-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i,

    output logic             stall_o,
    output logic [Width-1:0] dataR_o,
    output logic             misalign_o,
    output logic             bus_err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;

    // Bus request registers; they double as the latched we/addr/be/wdata.
    logic             req_q;
    logic             we_q;
    logic [Width-1:0] addr_q;
    logic [Width-1:0] wdata_q;
    logic [3:0]       be_q;

    // Fields still needed after the grant to extract the load result.
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;

    logic [Width-1:0] dataR_q;
    logic             bus_err_q;

    // Decode of the current MEM-stage access.
    logic             access;
    logic             code_ok;
    logic             aligned;
    logic             legal_acc;
    logic             illegal_acc;
    logic [3:0]       be_new;
    logic [Width-1:0] wdata_new;

    // FSM event strobes.
    logic             accept;
    logic             take_rdata;
    logic             timeout;

    // Load extraction.
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [Width-1:0] load_ext;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    assign access = ld_MEM | st_MEM;

    always_comb begin
        code_ok = 1'b0;
        if (ld_MEM) begin
            case (funct3_MEM)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
                default:                                code_ok = 1'b0;
            endcase
        end else if (st_MEM) begin
            case (funct3_MEM)
                3'b000, 3'b001, 3'b010: code_ok = 1'b1;
                default:                code_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3_MEM[1:0])
            2'b01:   aligned = ~alu_MEM[0];
            2'b10:   aligned = (alu_MEM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign legal_acc   = access & code_ok & aligned;
    assign illegal_acc = access & ~(code_ok & aligned);

    always_comb begin
        case (funct3_MEM[1:0])
            2'b00:   be_new = 4'b0001 << alu_MEM[1:0];
            2'b01:   be_new = 4'b0011 << alu_MEM[1:0];
            default: be_new = 4'b1111;
        endcase
    end

    // Store data is replicated across lanes so the byte enables pick it out.
    always_comb begin
        wdata_new = '0;
        if (st_MEM) begin
            case (funct3_MEM[1:0])
                2'b00:   wdata_new = {4{wdata_MEM[7:0]}};
                2'b01:   wdata_new = {2{wdata_MEM[15:0]}};
                default: wdata_new = wdata_MEM;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load extraction from the returned word
    // -------------------------------------------------------------------------
    assign byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'b0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'b0, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM next state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        accept     = 1'b0;
        take_rdata = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            StIdle: begin
                if (legal_acc) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    state_d = StReq;
                end else if (illegal_acc) begin
                    misalign_o = 1'b1;
                end
            end

            StReq: begin
                stall_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = we_q ? StDone : StWait;
                    cnt_d   = 8'd0;
                end
            end

            StWait: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                // A response in the last permitted cycle still wins over the timeout.
                if (mem_rvalid_i) begin
                    take_rdata = 1'b1;
                    state_d    = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    timeout = 1'b1;
                    state_d = StDone;
                end
            end

            StDone: begin
                // The instruction still present here already completed.
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields load on acceptance and clear on grant, so they are only
    // non-zero while in REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0;
        end else if (accept) begin
            req_q   <= 1'b1;
            we_q    <= st_MEM;
            addr_q  <= {alu_MEM[Width-1:2], 2'b00};
            wdata_q <= wdata_new;
            be_q    <= be_new;
        end else if ((state_q == StReq) && mem_gnt_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            funct3_q <= 3'b0;
            off_q    <= 2'b0;
        end else if (accept) begin
            funct3_q <= funct3_MEM;
            off_q    <= alu_MEM[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dataR_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (take_rdata) begin
                dataR_q <= load_ext;
            end else if (timeout) begin
                dataR_q <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign dataR_o     = dataR_q;
    assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_ctrl: directed vector table, hand-written reset sequences
// and randomized transactions checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b0;
    logic        ld_MEM       = 1'b0;
    logic        st_MEM       = 1'b0;
    logic [2:0]  funct3_MEM   = 3'b0;
    logic [31:0] alu_MEM      = 32'b0;
    logic [31:0] wdata_MEM    = 32'b0;
    logic        mem_gnt_i    = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i  = 32'b0;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        stall_o;
    logic [31:0] dataR_o;
    logic        misalign_o;
    logic        bus_err_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_data = 32'b0;

    typedef struct {
        bit          is_ld;
        bit [2:0]    f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gdly;
        int          rdly;   // -1: memory never responds
        logic [31:0] rdata;
        bit          legal;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] data;
        int          stall;
        bit          berr;
    } vec_t;

    vec_t vecs[$];
    vec_t rv;

    lsu_ctrl #(
        .Width         (32),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ld_MEM       (ld_MEM),
        .st_MEM       (st_MEM),
        .funct3_MEM   (funct3_MEM),
        .alu_MEM      (alu_MEM),
        .wdata_MEM    (wdata_MEM),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o),
        .dataR_o      (dataR_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " stall"}, 32'(stall_o), 32'd0);
        check({name, " req/we/be"}, 32'({mem_req_o, mem_we_o, mem_be_o}), 32'd0);
        check({name, " addr|wdata"}, mem_addr_o | mem_wdata_o, 32'd0);
        check({name, " dataR"}, dataR_o, 32'd0);
        check({name, " pulses"}, 32'({misalign_o, bus_err_o}), 32'd0);
    endtask

    task automatic idle();
        step();
        ld_MEM       = 1'b0;
        st_MEM       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        #1;
        check("idle stall", 32'(stall_o), 32'd0);
    endtask

    function automatic vec_t mk(bit ld, bit [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                int g, int r, logic [31:0] rdata, bit legal, logic [3:0] be,
                                logic [31:0] wd, logic [31:0] data, int stall, bit berr);
        vec_t v;
        v.is_ld = ld;    v.f3 = f3;      v.addr = addr;   v.wdata = wdata;
        v.gdly  = g;     v.rdly = r;     v.rdata = rdata; v.legal = legal;
        v.be    = be;    v.wd = wd;      v.data = data;   v.stall = stall;
        v.berr  = berr;
        return v;
    endfunction

    // Transaction-level reference: derives everything from size, offset and
    // the responder delays; updates the expected held load result.
    task automatic model(inout vec_t v);
        int          n;
        int          off;
        bit          code_ok;
        bit          tmo;
        logic [31:0] mask;
        logic [31:0] val;
        n   = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : (v.f3[1:0] == 2'd2) ? 4 : 0;
        off = int'(v.addr % 4);
        if (v.is_ld) code_ok = (n != 0) && !(v.f3[2] && n == 4);
        else         code_ok = (n != 0) && !v.f3[2];
        v.legal = code_ok && ((off % n) == 0);
        v.be    = v.legal ? 4'(((1 << n) - 1) << off) : 4'd0;
        v.wd    = 32'd0;
        if (v.legal && !v.is_ld) begin
            for (int i = 0; i < 4; i++) v.wd[8*i +: 8] = v.wdata[8*(i % n) +: 8];
        end
        tmo = (v.rdly < 0);
        if (v.legal && v.is_ld) begin
            if (tmo) begin
                exp_data = 32'd0;
            end else begin
                mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
                val  = (v.rdata >> (8 * off)) & mask;
                if (!v.f3[2] && n < 4 && val[8*n-1]) val = val | ~mask;
                exp_data = val;
            end
        end
        v.data = exp_data;
        if (!v.legal)      v.stall = 0;
        else if (!v.is_ld) v.stall = 2 + v.gdly;
        else               v.stall = 2 + v.gdly + (tmo ? int'(TO) : v.rdly + 1);
        v.berr = v.legal && v.is_ld && tmo;
    endtask

    // Presents one MEM-stage access and plays the memory side until DONE.
    task automatic run_access(input vec_t v, input string name);
        int stalls;
        int reqc;
        int wcnt;
        bit in_wait;
        bit done;
        step();
        ld_MEM       = v.is_ld;
        st_MEM       = !v.is_ld;
        funct3_MEM   = v.f3;
        alu_MEM      = v.addr;
        wdata_MEM    = v.wdata;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_rdata_i  = $urandom();
        #1;
        check({name, " idle stall"}, 32'(stall_o), 32'(v.legal));
        check({name, " misalign"}, 32'(misalign_o), 32'(!v.legal));
        check({name, " idle req"}, 32'(mem_req_o), 32'd0);
        if (!v.legal) begin
            check({name, " held dataR"}, dataR_o, v.data);
            return;
        end
        stalls  = stall_o ? 1 : 0;
        reqc    = 0;
        wcnt    = 0;
        in_wait = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            step();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom();
            if (in_wait) begin
                check({name, " no req after gnt"}, 32'(mem_req_o), 32'd0);
                if (v.is_ld && v.rdly == wcnt) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = v.rdata;
                end
                wcnt++;
            end else if (mem_req_o) begin
                check({name, " we"}, 32'(mem_we_o), 32'(!v.is_ld));
                check({name, " addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
                check({name, " wdata"}, mem_wdata_o, v.wd);
                check({name, " be"}, 32'(mem_be_o), 32'(v.be));
                if (reqc == v.gdly) begin
                    mem_gnt_i = 1'b1;
                    in_wait   = 1'b1;
                end else begin
                    mem_rvalid_i = 1'($urandom_range(0, 1));
                end
                reqc++;
            end
            #1;
            if (stall_o) begin
                stalls++;
                check({name, " no pulses"}, 32'({misalign_o, bus_err_o}), 32'd0);
            end else begin
                done = 1'b1;
                check({name, " dataR"}, dataR_o, v.data);
                check({name, " bus_err"}, 32'(bus_err_o), 32'(v.berr));
                check({name, " done req"}, 32'(mem_req_o), 32'd0);
            end
        end
        check({name, " reached done"}, 32'(done), 32'd1);
        check({name, " stall cycles"}, 32'(stalls), 32'(v.stall));
        check({name, " req cycles"}, 32'(reqc), 32'(v.gdly + 1));
    endtask

    initial begin
        // ld, f3, addr, wdata, gdly, rdly, rdata | legal, be, wd, data, stall, berr
        vecs.push_back(mk(1, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                          1, 4'hF, 32'h0, 32'hDEADBEEF, 3, 0));
        vecs.push_back(mk(1, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000,
                          1, 4'h8, 32'h0, 32'hFFFFFF80, 3, 0));
        vecs.push_back(mk(1, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000,
                          1, 4'h8, 32'h0, 32'h00000080, 3, 0));
        vecs.push_back(mk(0, 3'b001, 32'h102, 32'h1234ABCD, 2, 0, 32'h0,
                          1, 4'hC, 32'hABCDABCD, 32'h00000080, 4, 0));
        vecs.push_back(mk(1, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h00000080, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h200, 32'h55, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h00000080, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h104, 32'h0, 0, -1, 32'h0,
                          1, 4'hF, 32'h0, 32'h0, 6, 1));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h0, 1, 2, 32'h80011234,
                          1, 4'hC, 32'h0, 32'hFFFF8001, 6, 0));
        vecs.push_back(mk(1, 3'b101, 32'h100, 32'h0, 0, 1, 32'h0000F00D,
                          1, 4'h3, 32'h0, 32'h0000F00D, 4, 0));
        vecs.push_back(mk(0, 3'b000, 32'h101, 32'h000000A5, 1, 0, 32'h0,
                          1, 4'h2, 32'hA5A5A5A5, 32'h0000F00D, 3, 0));
        vecs.push_back(mk(0, 3'b010, 32'h10C, 32'hCAFEF00D, 0, 0, 32'h0,
                          1, 4'hF, 32'hCAFEF00D, 32'h0000F00D, 2, 0));
        vecs.push_back(mk(1, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h0000F00D, 0, 0));
        vecs.push_back(mk(1, 3'b110, 32'h100, 32'h0, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h0000F00D, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h0000F00D, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0,
                          0, 4'h0, 32'h0, 32'h0000F00D, 0, 0));
        vecs.push_back(mk(1, 3'b000, 32'h100, 32'h0, 0, 3, 32'h1234567F,
                          1, 4'h1, 32'h0, 32'h0000007F, 6, 0));
        vecs.push_back(mk(1, 3'b001, 32'h100, 32'h0, 3, -1, 32'h0,
                          1, 4'h3, 32'h0, 32'h0, 9, 1));
        vecs.push_back(mk(1, 3'b010, 32'h040, 32'h0, 0, 0, 32'h13579BDF,
                          1, 4'hF, 32'h0, 32'h13579BDF, 3, 0));

        // Reset state, during and after reset.
        step();
        check_all_zero("in reset");
        step();
        rst_ni = 1'b1;
        step();
        check_all_zero("after reset");

        // Directed table, applied back to back.
        foreach (vecs[i]) run_access(vecs[i], $sformatf("vec%0d", i));
        idle();

        // Reset asserted while waiting for read data.
        step();
        ld_MEM     = 1'b1;
        st_MEM     = 1'b0;
        funct3_MEM = 3'b010;
        alu_MEM    = 32'h40;
        #1;
        check("rst seq idle stall", 32'(stall_o), 32'd1);
        step();
        mem_gnt_i = 1'b1;
        #1;
        check("rst seq req", 32'(mem_req_o), 32'd1);
        step();
        mem_gnt_i = 1'b0;
        #1;
        check("rst seq wait stall", 32'(stall_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        ld_MEM = 1'b0;
        #1;
        check_all_zero("mid-wait reset");
        step();
        step();
        rst_ni = 1'b1;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFFFFFF;
        #1;
        check("late rvalid stall", 32'(stall_o), 32'd0);
        check("late rvalid req", 32'(mem_req_o), 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        #1;
        check("late rvalid dataR", dataR_o, 32'd0);
        check("late rvalid stall after", 32'(stall_o), 32'd0);
        exp_data = 32'd0;

        // Randomized traffic against the model.
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            rv.is_ld = 1'($urandom_range(0, 1));
            rv.f3    = 3'($urandom_range(0, 7));
            a        = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (rv.f3[1:0] == 2'b01)      a[0]   = 1'b0;
                else if (rv.f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            rv.addr  = a;
            rv.wdata = $urandom();
            rv.rdata = $urandom();
            rv.gdly  = int'($urandom_range(0, 3));
            rv.rdly  = int'($urandom_range(0, TO));
            if (rv.rdly == int'(TO)) rv.rdly = -1;
            model(rv);
            run_access(rv, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
